rtc_bus_arbiter: RTL and testbench
==================================

Name: rtc_bus_arbiter

Overview:
- Shares the multiplexed address/data bus of the external RTC chip (AD, CS, RD, WR strobes, 8-bit AD bus) between NREQ internal requesters: init sequencer, periodic time reader, user-setting writer.
- Each granted request runs one complete RTC transaction: address phase followed by data phase, read or write.
- For reads, the block returns the captured data to the requester.
- Sits between the requesters and the top-level bus pins.

Parameters:
- NREQ, 3, number of requesters (2..8)
- BUS, 8, address/data width
- T_PULSE, 5, cycles WR/RD is held low in each phase (>=2)
- T_GAP, 8, idle cycles between address phase end and data phase start (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  NREQ  request per requester; held high until matching done
- req_wr  in  NREQ  1=write, 0=read; sampled at grant
- req_addr  in  NREQ*BUS  packed register address; slice i belongs to requester i
- req_wdata  in  NREQ*BUS  packed write data
- gnt  out  NREQ  one-hot; high for the whole transaction
- done  out  NREQ  1-cycle pulse at transaction end
- rdata  out  BUS  read data; valid in the done cycle, held until next read
- busy  out  1  high from grant through done
- CS, RD, WR, AD  out  1 each  RTC strobes, active-low
- ad_out  out  BUS  bus drive value
- ad_oe  out  1  tri-state enable for ad_out
- ad_in  in  BUS  bus sampled value

Behaviour:
- Reset values: CS=RD=WR=AD=1, ad_out=8'hFF, ad_oe=0, gnt=0, done=0, busy=0, rdata=0, rr pointer=NREQ-1 (requester 0 wins first). State returns to IDLE.
- Reset mid-transaction: outputs take reset values at the next edge. No partial phase completes. No done is pulsed.
- IDLE: if any req, choose the winner round-robin starting at pointer+1. Latch addr, wdata, wr. Assert gnt and busy. Pointer <= winner. Go to A_SET. Grant latency is 1 cycle from req.
- Address phase, in cycles after grant (k=0 is the A_SET cycle):
  - k=0: AD=0, ad_oe=1, ad_out=addr.
  - k=1: CS=0.
  - k=2: WR=0 (address is always latched with WR).
  - k=2+T_PULSE: WR=1.
  - +1: CS=1.
  - +1: AD=1.
  - +1: ad_out=FF, ad_oe=0.
- GAP: T_GAP cycles with all strobes high.
- Data phase:
  - Cycle d0: CS=0.
  - d1: write drives WR=0, ad_oe=1, ad_out=wdata. Read drives RD=0 with ad_oe=0.
  - Strobe is held low T_PULSE cycles. Read captures ad_in into rdata on the edge where RD returns high.
  - Next cycle: CS=1.
  - Next cycle: ad_out=FF, ad_oe=0, done[winner]=1.
  - Following cycle: gnt=0, busy=0, back to IDLE.
- Minimum spacing: one IDLE cycle between consecutive transactions, even if req stays high.
- A single cycle counter (>= log2(max(T_PULSE,T_GAP))+1 bits) times the holds. It clears on every state change.
- req dropped mid-transaction: ignored, transaction completes, done still pulses. req raised during busy: waits.
- Never more than one of RD/WR low. RD is never low while ad_oe=1.
- Only one gnt bit is ever set. done always matches the gnt bit in the same cycle.

Optional Feature:
- Macro RTC_BUS_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer is unused.
- Undefined: round-robin as above.

Test Plan:
- req[0] write, addr 8'h43, wdata 8'h00 -> AD low 1 cycle before CS; WR low 5 cycles with ad_out=43; gap 8 cycles; WR low 5 cycles with ad_out=00; done[0] at cycle 2+5+3+1+8+1+5+2 after grant; never RD=0.
- req[1] read, addr 8'h42, ad_in=8'h27 during RD low -> RD low 5 cycles with ad_oe=0; rdata=8'h27 in the done[1] cycle; WR low only in the address phase.
- req=3'b111 all held after reset -> grant order 0,1,2,0 with one IDLE cycle between; each done matches gnt.
- req[0] and req[2] held continuously -> grants alternate 0,2,0,2; req[1] low is never granted.
- Assert reset in the data-phase write strobe cycle -> next cycle CS=RD=WR=AD=1, ad_oe=0, ad_out=FF, gnt=0, no done; after release, requester 0 wins first.
- With RTC_BUS_FIXED_PRIO_EN, req[0] and req[2] held -> requester 0 granted every time, requester 2 starved until req[0] drops.

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter
//
// Shares the multiplexed address/data bus of the external RTC chip between
// NREQ internal requesters (init sequencer, periodic time reader, user-setting
// writer). Each grant runs one complete RTC transaction: an address phase
// (address always latched with WR) followed by a data phase (read or write).
// Read data is captured and returned to the requester.
//
// Optional feature (compile-time macro):
//   RTC_BUS_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                          undefined -> round-robin starting after last winner
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high
//   req        in   [NREQ]      request per requester, held until its done
//   req_wr     in   [NREQ]      1=write, 0=read; sampled at grant
//   req_addr   in   [NREQ*BUS]  packed register address, slice i = requester i
//   req_wdata  in   [NREQ*BUS]  packed write data
//   gnt        out  [NREQ]      one-hot grant, high for the whole transaction
//   done       out  [NREQ]      1-cycle pulse at transaction end
//   rdata      out  [BUS]       read data, valid in done cycle, held until next read
//   busy       out              high from grant through done
//   CS,RD,WR,AD out             RTC strobes, active-low
//   ad_out     out  [BUS]       bus drive value
//   ad_oe      out              tri-state enable for ad_out
//   ad_in      in   [BUS]       bus sampled value
// ---------------------------------------------------------------------------
module rtc_bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int BUS     = 8,
    parameter int T_PULSE = 5,
    parameter int T_GAP   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*BUS-1:0]  req_addr,
    input  logic [NREQ*BUS-1:0]  req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [BUS-1:0]       rdata,
    output logic                 busy,
    output logic                 CS,
    output logic                 RD,
    output logic                 WR,
    output logic                 AD,
    output logic [BUS-1:0]       ad_out,
    output logic                 ad_oe,
    input  logic [BUS-1:0]       ad_in
);

    localparam int IW   = $clog2(NREQ);
    localparam int CMAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
    localparam int CW   = $clog2(CMAX) + 1;

    // One state per distinct bus cycle of the transaction; the strobe and
    // gap states stretch over several cycles using the shared counter.
    typedef enum logic [3:0] {
        IDLE,   // waiting for a request
        A_SET,  // AD low, address driven
        A_CS,   // CS low
        A_STB,  // WR low for T_PULSE cycles
        A_REL,  // WR back high
        A_CSH,  // CS back high
        A_ADH,  // AD back high
        A_END,  // bus released
        GAP,    // T_GAP idle cycles
        D_CS,   // CS low
        D_STB,  // RD or WR low for T_PULSE cycles
        D_REL,  // strobe back high (read data captured on entry)
        D_CSH,  // CS back high
        D_DONE  // done pulse
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              wr_q;
    logic [BUS-1:0]    wdata_q;
    logic [IW-1:0]     win;
    logic              win_vld;

`ifdef RTC_BUS_FIXED_PRIO_EN
    // Scan from the top down so the lowest requesting index is assigned last.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win     = IW'(i);
                win_vld = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;

    // Search offsets NREQ..1 from the last winner; the smallest offset is
    // visited last, so the requester closest after ptr wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch sees the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            rdata   <= '0;
            CS      <= 1'b1;
            RD      <= 1'b1;
            WR      <= 1'b1;
            AD      <= 1'b1;
            ad_out  <= '1;
            ad_oe   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
`ifndef RTC_BUS_FIXED_PRIO_EN
            ptr     <= IW'(NREQ - 1);
`endif
        end else begin
            // The counter clears whenever the state changes; only the
            // multi-cycle states below advance it while they hold.
            cnt  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt     <= NREQ'(1) << win;
                        busy    <= 1'b1;
                        wr_q    <= req_wr[win];
                        wdata_q <= req_wdata[int'(win)*BUS +: BUS];
                        ad_out  <= req_addr[int'(win)*BUS +: BUS];
                        ad_oe   <= 1'b1;
                        AD      <= 1'b0;
`ifndef RTC_BUS_FIXED_PRIO_EN
                        ptr     <= win;
`endif
                        state   <= A_SET;
                    end
                end
                A_SET: begin
                    CS    <= 1'b0;
                    state <= A_CS;
                end
                A_CS: begin
                    WR    <= 1'b0;
                    state <= A_STB;
                end
                A_STB: begin
                    if (cnt == CW'(T_PULSE - 1)) begin
                        WR    <= 1'b1;
                        state <= A_REL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                A_REL: begin
                    CS    <= 1'b1;
                    state <= A_CSH;
                end
                A_CSH: begin
                    AD    <= 1'b1;
                    state <= A_ADH;
                end
                A_ADH: begin
                    ad_out <= '1;
                    ad_oe  <= 1'b0;
                    state  <= A_END;
                end
                A_END: begin
                    state <= GAP;
                end
                GAP: begin
                    if (cnt == CW'(T_GAP - 1)) begin
                        CS    <= 1'b0;
                        state <= D_CS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                D_CS: begin
                    // Reads leave the bus undriven so RD is never low with ad_oe set.
                    if (wr_q) begin
                        WR     <= 1'b0;
                        ad_oe  <= 1'b1;
                        ad_out <= wdata_q;
                    end else begin
                        RD <= 1'b0;
                    end
                    state <= D_STB;
                end
                D_STB: begin
                    if (cnt == CW'(T_PULSE - 1)) begin
                        WR <= 1'b1;
                        RD <= 1'b1;
                        // Sample on the same edge that raises RD.
                        if (!wr_q) rdata <= ad_in;
                        state <= D_REL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                D_REL: begin
                    CS    <= 1'b1;
                    state <= D_CSH;
                end
                D_CSH: begin
                    ad_out <= '1;
                    ad_oe  <= 1'b0;
                    done   <= gnt;
                    state  <= D_DONE;
                end
                D_DONE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_arbiter
//
// Table of whole transactions (requests, direction, address, data, bus read
// value, expected winner and read data). Each entry is applied and every
// cycle from grant to the following IDLE cycle is compared against the
// expected strobe timeline. Hand-written sequences cover reset in the middle
// of a data-phase write strobe and the all-requesters-held grant order.
// ---------------------------------------------------------------------------
module tb_rtc_bus_arbiter;

    localparam int NREQ  = 3;
    localparam int BUS   = 8;
    localparam int TP    = 5;
    localparam int TG    = 8;
    // Cycle of the done pulse, counted from the first grant cycle (k=0).
    localparam int KDONE = 2 + TP + 3 + 1 + TG + 1 + TP + 2;
    // First data-phase cycle (CS low).
    localparam int D0    = KDONE - TP - 3;
`ifdef RTC_BUS_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_wr;
    logic [NREQ*BUS-1:0] req_addr;
    logic [NREQ*BUS-1:0] req_wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [BUS-1:0]      rdata;
    logic                busy;
    logic                CS, RD, WR, AD;
    logic [BUS-1:0]      ad_out;
    logic                ad_oe;
    logic [BUS-1:0]      ad_in;
    logic [BUS-1:0]      cur_ad_in;

    int n_tests = 0;
    int n_fail  = 0;

    rtc_bus_arbiter #(.NREQ(NREQ), .BUS(BUS), .T_PULSE(TP), .T_GAP(TG)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .CS        (CS),
        .RD        (RD),
        .WR        (WR),
        .AD        (AD),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .ad_in     (ad_in)
    );

    always #5 clk = ~clk;

    // The RTC only drives valid data while RD is low.
    assign ad_in = RD ? 8'hEE : cur_ad_in;

    typedef struct {
        logic [NREQ-1:0] req;
        logic            wr;
        logic [BUS-1:0]  addr;
        logic [BUS-1:0]  wdata;
        logic [BUS-1:0]  rd_val;
        int              win_rr;
        int              win_fp;
        logic [BUS-1:0]  exp_rdata;
        bit              drop;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] observed();
        return {gnt, done, busy, CS, RD, WR, AD, ad_oe, ad_out};
    endfunction

    localparam logic [19:0] RESET_VEC = {3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};

    // Expected outputs in cycle k after grant, from the transaction timeline.
    function automatic logic [19:0] exp_vec(input int k, input int win, input logic wr,
                                            input logic [7:0] addr, input logic [7:0] wdata);
        logic [2:0] g, d;
        logic b, cs_e, rd_e, wr_e, ad_e, oe_e;
        logic [7:0] o;
        g    = (k <= KDONE) ? 3'(1 << win) : 3'b000;
        d    = (k == KDONE) ? g : 3'b000;
        b    = (k <= KDONE);
        cs_e = !((k >= 1 && k <= 2 + TP) || (k >= D0 && k <= D0 + TP + 1));
        ad_e = !(k <= 3 + TP);
        wr_e = !((k >= 2 && k <= 1 + TP) || (wr && k >= D0 + 1 && k <= D0 + TP));
        rd_e = !(!wr && k >= D0 + 1 && k <= D0 + TP);
        oe_e = (k <= 4 + TP) || (wr && k >= D0 + 1 && k <= KDONE - 1);
        if (k <= 4 + TP)                          o = addr;
        else if (wr && k >= D0 + 1 && k <= KDONE - 1) o = wdata;
        else                                      o = 8'hFF;
        return {g, d, b, cs_e, rd_e, wr_e, ad_e, oe_e, o};
    endfunction

    // Winner slice gets the vector's values; other slices get distinct values
    // and the opposite direction so a wrong slice choice is visible.
    task automatic drive(input vec_t v, input int win);
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*BUS +: BUS]  = (i == win) ? v.addr  : (v.addr  ^ 8'h80 ^ 8'(i));
            req_wdata[i*BUS +: BUS] = (i == win) ? v.wdata : (v.wdata ^ 8'h80 ^ 8'(i));
            req_wr[i]               = (i == win) ? v.wr : !v.wr;
        end
        cur_ad_in = v.rd_val;
        req       = v.req;
    endtask

    task automatic wait_grant(input string name, output bit ok);
        int steps;
        steps = 0;
        do begin
            @(negedge clk);
            steps++;
        end while (gnt == '0 && steps < 8);
        check({name, " grant latency"}, 32'(steps), 32'd1);
        ok = (gnt != '0);
    endtask

    task automatic run_txn(input vec_t v, input string name);
        int win;
        bit ok;
        win = FP ? v.win_fp : v.win_rr;
        drive(v, win);
        wait_grant(name, ok);
        if (ok) begin
            for (int k = 0; k <= KDONE + 1; k++) begin
                if (k > 0) @(negedge clk);
                check($sformatf("%s k%0d bus", name, k), 32'(observed()),
                      32'(exp_vec(k, win, v.wr, v.addr, v.wdata)));
                if (k == KDONE)
                    check($sformatf("%s rdata", name), 32'(rdata), 32'(v.exp_rdata));
                if (v.drop && k == 5) req = '0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t s;
        bit   ok;
        int   w;
        //          req     wr    addr   wdata  rd_val rr fp rdata  drop
        vecs[0]  = '{3'b001, 1'b1, 8'h43, 8'h00, 8'h00, 0, 0, 8'h00, 1'b0};
        vecs[1]  = '{3'b010, 1'b0, 8'h42, 8'h00, 8'h27, 1, 1, 8'h27, 1'b0};
        vecs[2]  = '{3'b111, 1'b1, 8'h10, 8'hA5, 8'h00, 2, 0, 8'h27, 1'b0};
        vecs[3]  = '{3'b111, 1'b0, 8'h20, 8'h00, 8'h3C, 0, 0, 8'h3C, 1'b0};
        vecs[4]  = '{3'b111, 1'b1, 8'h31, 8'h5A, 8'h00, 1, 0, 8'h3C, 1'b0};
        vecs[5]  = '{3'b111, 1'b0, 8'h7F, 8'h00, 8'hC3, 2, 0, 8'hC3, 1'b0};
        vecs[6]  = '{3'b101, 1'b1, 8'h55, 8'hAA, 8'h00, 0, 0, 8'hC3, 1'b0};
        vecs[7]  = '{3'b101, 1'b0, 8'h66, 8'h00, 8'h99, 2, 0, 8'h99, 1'b0};
        vecs[8]  = '{3'b101, 1'b1, 8'hFF, 8'hFF, 8'h00, 0, 0, 8'h99, 1'b0};
        vecs[9]  = '{3'b101, 1'b0, 8'h00, 8'h00, 8'h00, 2, 0, 8'h00, 1'b0};
        vecs[10] = '{3'b010, 1'b0, 8'hFF, 8'h00, 8'hFF, 1, 1, 8'hFF, 1'b1};

        reset     = 1'b1;
        req       = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        cur_ad_in = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'(observed()), 32'(RESET_VEC));
        check("reset rdata", 32'(rdata), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset during the data-phase write strobe.
        s = '{3'b001, 1'b1, 8'h43, 8'h5C, 8'h00, 0, 0, 8'h00, 1'b0};
        drive(s, 0);
        wait_grant("abort", ok);
        if (ok) begin
            repeat (D0 + 2) @(negedge clk);
            check("abort pre-reset bus", 32'(observed()),
                  32'(exp_vec(D0 + 2, 0, 1'b1, 8'h43, 8'h5C)));
            reset = 1'b1;
            @(negedge clk);
            check("abort reset outputs", 32'(observed()), 32'(RESET_VEC));
            check("abort reset rdata", 32'(rdata), 32'h0);
        end
        reset = 1'b0;

        // All requesters held after reset: requester 0 first, then rotation.
        for (int t = 0; t < 4; t++) begin
            w = FP ? 0 : (t % 3);
            s.req       = 3'b111;
            s.wr        = (t % 2 == 0);
            s.addr      = 8'(8'h11 + 8'h22 * t);
            s.wdata     = 8'(8'h22 + 8'h22 * t);
            s.rd_val    = 8'(8'h44 + 8'h44 * (t / 2));
            s.win_rr    = w;
            s.win_fp    = w;
            s.exp_rdata = (t == 0) ? 8'h00 : (t < 3) ? 8'h44 : 8'h88;
            s.drop      = 1'b0;
            run_txn(s, $sformatf("all%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
